// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit.
//
// Runs the eight M-extension ops (funct3 on `op`). Multiplies use a radix-2
// shift-add datapath and divides a restoring shift-subtract. Both work on
// operand magnitudes and apply sign correction in a single FIX cycle.
// Divide-by-zero and signed DIV overflow skip iteration and go straight to
// DONE.
//
// Handshakes (valid/ready):
//   - A transfer happens on a rising edge where valid && ready are both high.
//   - Once valid is raised, the producer holds it and its data until the
//     transfer.
//   - The input side is ready only in IDLE, and an op offered with flush is
//     refused.
//   - The output side holds out_valid and result until out_ready is seen.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   flush             synchronous kill of any in-flight or held op
//   in_valid/in_ready operand handshake (ready only in IDLE)
//   op                funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   operand_a/b       rs1 / rs2 values
//   out_valid/ready   result handshake
//   result            registered result
//   busy              high in any state except IDLE
//   dbg_state         current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
module mul_div_unit #(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [DataWidth-1:0] operand_a,
    input  logic [DataWidth-1:0] operand_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] result,
    output logic                 busy,
    output logic [1:0]           dbg_state
);
    localparam int CntW = $clog2(DataWidth);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [2:0]           op_q;
    logic [DataWidth-1:0] b_mag_q;
    // Multiply: {hi, lo} is the product register; lo starts as the multiplier.
    // Divide: hi is the partial remainder; lo starts as the dividend and
    // collects quotient bits as they come out.
    logic [DataWidth-1:0] hi_q, lo_q;
    logic [CntW-1:0]      cnt_q;
    logic                 neg_res_q, neg_rem_q;
    logic [DataWidth-1:0] result_q;

    // ---------------- operand decode ----------------
    logic                 a_signed, b_signed, a_neg, b_neg;
    logic [DataWidth-1:0] a_mag, b_mag;
    logic                 div_zero, div_ovf, fast;
    logic [DataWidth-1:0] fast_result;
    logic                 accept;

    assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign a_neg    = a_signed && operand_a[DataWidth-1];
    assign b_neg    = b_signed && operand_b[DataWidth-1];
    assign a_mag    = a_neg ? (~operand_a + 1'b1) : operand_a;
    assign b_mag    = b_neg ? (~operand_b + 1'b1) : operand_b;

    assign div_zero = op[2] && (operand_b == '0);
    // Only the signed divide ops (op[0] == 0) can overflow.
    assign div_ovf  = op[2] && !op[0] && (operand_b == '1) &&
                      (operand_a == {1'b1, {(DataWidth-1){1'b0}}});
    assign fast     = div_zero || div_ovf;

    always_comb begin
        fast_result = '0;
        if (div_zero) fast_result = op[1] ? operand_a : '1;
        else if (div_ovf) fast_result = op[1] ? '0 : operand_a;
    end

    assign accept = in_valid && in_ready && !flush;

    // ---------------- iteration step ----------------
    logic [DataWidth:0]   mul_sum, div_shift, div_diff;
    logic                 div_ge;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag_q} : '0);
    assign div_shift = {hi_q, lo_q[DataWidth-1]};
    assign div_diff  = div_shift - {1'b0, b_mag_q};
    // The partial remainder is always below the divisor, so the borrow bit
    // alone tells whether the trial subtraction fits.
    assign div_ge    = !div_diff[DataWidth];

    // ---------------- sign fix / output select ----------------
    logic [2*DataWidth-1:0] prod_fix;
    logic [DataWidth-1:0]   quot_fix, rem_fix, fix_result;

    assign prod_fix = neg_res_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    assign quot_fix = neg_res_q ? (~lo_q + 1'b1) : lo_q;
    assign rem_fix  = neg_rem_q ? (~hi_q + 1'b1) : hi_q;

    always_comb begin
        fix_result = '0;
        case (op_q)
            3'b000:                 fix_result = prod_fix[DataWidth-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*DataWidth-1:DataWidth];
            3'b100, 3'b101:         fix_result = quot_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = fast ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == CntW'(DataWidth - 1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            b_mag_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q      <= op;
                        b_mag_q   <= b_mag;
                        hi_q      <= '0;
                        lo_q      <= a_mag;
                        cnt_q     <= '0;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (fast) result_q <= fast_result;
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (!op_q[2]) begin
                            {hi_q, lo_q} <= {mul_sum, lo_q[DataWidth-1:1]};
                        end else begin
                            hi_q <= div_ge ? div_diff[DataWidth-1:0] : div_shift[DataWidth-1:0];
                            lo_q <= {lo_q[DataWidth-2:0], div_ge};
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                S_FIX: if (!flush) result_q <= fix_result;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed bench for mul_div_unit at DataWidth = 32.
module tb_mul_div_unit;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mul_div_unit #(.DataWidth(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- drivers ----------------
    // Present one op for exactly one edge (unit must be in IDLE).
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; operand_a = a; operand_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accepting edge (counted as 1) until out_valid.
    // Gives up at 100; the caller's latency comparison then fails.
    task automatic wait_valid(output int lat, output bit rdy_seen);
        lat = 1;
        rdy_seen = in_ready;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            rdy_seen |= in_ready;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit rdy_seen);
        issue(o, a, b);
        wait_valid(lat, rdy_seen);
        res = result;
        take();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ov=%b busy=%b rdy=%b res=%h, want 0 0 1 00000000",
                     out_valid, busy, in_ready, result);
        end
    endtask

    task automatic test_multiply();
        logic [2:0]  ops[4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        logic [31:0] as[4]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs[4]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex[4]  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res, want;
        int lat;
        bit rdy;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ex[i]);
            run_op(ops[i], as[i], bs[i], res, lat, rdy);
            want = exp_q.pop_front();
            checks++;
            if (res !== want) begin
                errors++;
                $display("FAIL mul_result[%0d] op=%0d: got %h want %h", i, ops[i], res, want);
            end
            checks++;
            if (lat !== 34) begin
                errors++;
                $display("FAIL mul_latency[%0d]: got %0d want 34", i, lat);
            end
            checks++;
            if (rdy !== 1'b0) begin
                errors++;
                $display("FAIL mul_in_ready_low[%0d]: in_ready seen high while busy", i);
            end
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_back_to_idle: busy=%b rdy=%b want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_divide();
        logic [2:0]  ops[5] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101};
        logic [31:0] as[5]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100};
        logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd7};
        logic [31:0] ex[5]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1, 32'd14};
        logic [31:0] res, want;
        int lat;
        bit rdy;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ex[i]);
            run_op(ops[i], as[i], bs[i], res, lat, rdy);
            want = exp_q.pop_front();
            checks++;
            if (res !== want) begin
                errors++;
                $display("FAIL div_result[%0d] op=%0d: got %h want %h", i, ops[i], res, want);
            end
            checks++;
            if (lat !== 34) begin
                errors++;
                $display("FAIL div_latency[%0d]: got %0d want 34", i, lat);
            end
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  ops[4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] as[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex[4]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res, want;
        int lat;
        bit rdy;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ex[i]);
            run_op(ops[i], as[i], bs[i], res, lat, rdy);
            want = exp_q.pop_front();
            checks++;
            if (res !== want) begin
                errors++;
                $display("FAIL fast_result[%0d] op=%0d: got %h want %h", i, ops[i], res, want);
            end
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL fast_latency[%0d]: got %0d want 1", i, lat);
            end
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        bit rdy;
        bit stable = 1'b1;
        // MULHU 0x10000 x 0x30000 = 0x3_0000_0000 -> high word 3
        issue(3'b011, 32'h0001_0000, 32'h0003_0000);
        wait_valid(lat, rdy);
        // Offer another op during the hold; it must be ignored.
        op = 3'b000; operand_a = 32'd9; operand_b = 32'd9; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: ov=%b res=%h rdy=%b want 1 00000003 0", out_valid, result, in_ready);
        end
        take();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL bp_release: ov=%b busy=%b rdy=%b st=%0d want 0 0 1 0",
                     out_valid, busy, in_ready, dbg_state);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat;
        bit rdy;
        bit saw_valid = 1'b0;
        bit res_kept = 1'b1;
        // result currently holds 3 from the back-pressure test
        issue(3'b000, 32'd1000, 32'd1000);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (dbg_state !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_to_idle: st=%0d ov=%b want 0 0", dbg_state, out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
            if (result !== 32'd3) res_kept = 1'b0;
        end
        checks++;
        if (saw_valid !== 1'b0 || res_kept !== 1'b1) begin
            errors++;
            $display("FAIL flush_no_output: saw_valid=%b result=%h want 0 00000003", saw_valid, result);
        end
        // flush together with in_valid in IDLE: op refused
        op = 3'b000; operand_a = 32'd2; operand_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_refuses_op: busy=%b want 0", busy);
        end
        exp_q.push_back(32'd14);
        run_op(3'b101, 32'd100, 32'd7, res, lat, rdy);
        checks++;
        if (res !== exp_q.pop_front() || lat !== 34) begin
            errors++;
            $display("FAIL flush_next_op: got %h lat %0d want 0000000e lat 34", res, lat);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat;
        bit rdy;
        issue(3'b000, 32'd5, 32'd6);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ov=%b res=%h busy=%b want 0 00000000 0", out_valid, result, busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: rdy=%b want 1", in_ready);
        end
        exp_q.push_back(32'd12);
        run_op(3'b000, 32'd3, 32'd4, res, lat, rdy);
        checks++;
        if (res !== exp_q.pop_front() || lat !== 34) begin
            errors++;
            $display("FAIL post_reset_mul: got %h lat %0d want 0000000c lat 34", res, lat);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        apply_reset();
        test_reset();
        test_multiply();
        test_divide();
        test_fast_path();
        test_back_pressure();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a wait loop is ever broken.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end
endmodule
